// File: rtl/top2_stream_merge.sv
// Running top-2 merge over a frame of sorted beat pairs; emits the frame-wide
// top-2 values, IDs and saturating beat count through a valid/ready handshake.
module top2_stream_merge #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [ID_W-1:0]   in_id_0,
  input  logic [ID_W-1:0]   in_id_1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data_0,
  output logic [DATA_W-1:0] out_data_1,
  output logic [ID_W-1:0]   out_id_0,
  output logic [ID_W-1:0]   out_id_1,
  output logic [CNT_W-1:0]  out_beats
);

  typedef struct packed {
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [ID_W-1:0]   i0;
    logic [ID_W-1:0]   i1;
  } pair_t;

  pair_t             run, inc, mrg, nxt;
  logic [CNT_W-1:0]  run_cnt, cnt_nxt;
  logic              first;
  logic              accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign inc      = '{d0: in_data_0, d1: in_data_1, i0: in_id_0, i1: in_id_1};

  // Ties resolve toward the running (earlier) entry.
  always_comb begin
    mrg = run;
    if ($signed(run.d0) >= $signed(inc.d0)) begin
      mrg.d0 = run.d0;
      mrg.i0 = run.i0;
      if ($signed(run.d1) >= $signed(inc.d0)) begin
        mrg.d1 = run.d1;
        mrg.i1 = run.i1;
      end else begin
        mrg.d1 = inc.d0;
        mrg.i1 = inc.i0;
      end
    end else begin
      mrg.d0 = inc.d0;
      mrg.i0 = inc.i0;
      if ($signed(run.d0) >= $signed(inc.d1)) begin
        mrg.d1 = run.d0;
        mrg.i1 = run.i0;
      end else begin
        mrg.d1 = inc.d1;
        mrg.i1 = inc.i1;
      end
    end
  end

  always_comb begin
    nxt     = first ? inc : mrg;
    cnt_nxt = run_cnt;
    if (first)
      cnt_nxt = CNT_W'(1);
    else if (run_cnt != {CNT_W{1'b1}})
      cnt_nxt = run_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run        <= '0;
      run_cnt    <= '0;
      first      <= 1'b1;
      out_valid  <= 1'b0;
      out_data_0 <= '0;
      out_data_1 <= '0;
      out_id_0   <= '0;
      out_id_1   <= '0;
      out_beats  <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        if (in_last) begin
          // A reload in the same cycle as a take overrides the clear above.
          out_valid  <= 1'b1;
          out_data_0 <= nxt.d0;
          out_data_1 <= nxt.d1;
          out_id_0   <= nxt.i0;
          out_id_1   <= nxt.i1;
          out_beats  <= cnt_nxt;
          run        <= '0;
          run_cnt    <= '0;
          first      <= 1'b1;
        end else begin
          run        <= nxt;
          run_cnt    <= cnt_nxt;
          first      <= 1'b0;
        end
      end
    end
  end

endmodule
